// File: rtl/slow_domain_rx_if.sv
// Toggle request/ack link from the slow domain plus the valid/ready sink it feeds.
// The receiver uses the slave modport; the source/sink side uses master.
interface slow_domain_rx_if #(
  parameter int unsigned DW = 32
);
  logic          src_req_tgl;
  logic [DW-1:0] src_data;
  logic          src_ack_tgl;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;

  modport master (
    output src_req_tgl,
    output src_data,
    output out_ready,
    input  src_ack_tgl,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  src_req_tgl,
    input  src_data,
    input  out_ready,
    output src_ack_tgl,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/slow_domain_rx.sv
// clk_in-domain receiver for words sent by the slow core over a toggle handshake,
// plus a monitor of the divided clock (edge strobes, half-period, stall).
//
// state    | meaning
// ST_IDLE  | nothing held; a pending request toggle is captured
// ST_VALID | word presented on out_data, waiting for out_ready
module slow_domain_rx #(
  parameter int unsigned DW          = 32,
  parameter int unsigned CW          = 10,
  parameter int unsigned STALL_LIMIT = 1023
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  slow_clk,
  slow_domain_rx_if.slave       bus,
  output logic                  overrun_err,
  input  logic                  overrun_clr,
  output logic                  slow_rise,
  output logic                  slow_fall,
  output logic [CW-1:0]         half_period,
  output logic                  hp_valid,
  output logic                  clk_stall
);

  localparam logic [0:0]    ST_IDLE   = 1'b0;
  localparam logic [0:0]    ST_VALID  = 1'b1;
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0] STALL_VAL = CW'(STALL_LIMIT);

  logic          req_ff1_q, req_ff1_d;
  logic          req_s_q, req_s_d;
  logic          req_seen_q, req_seen_d;
  logic [0:0]    state_q, state_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          ack_q, ack_d;
  logic          overrun_q, overrun_d;

  logic          slow_ff1_q, slow_ff1_d;
  logic          slow_s_q, slow_s_d;
  logic          slow_prev_q, slow_prev_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] hp_cnt_q, hp_cnt_d;
  logic [CW-1:0] half_period_q, half_period_d;
  logic          edge_seen_q, edge_seen_d;
  logic          hp_valid_q, hp_valid_d;
  logic          stall_q, stall_d;

  logic          req_pend;
  logic          slow_edge;
  logic [CW-1:0] hp_inc;

  always_comb begin
    req_ff1_d   = bus.src_req_tgl;
    req_s_d     = req_ff1_q;
    req_seen_d  = req_seen_q;
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    ack_d       = ack_q;
    overrun_d   = overrun_q & ~overrun_clr;
    req_pend    = (req_s_q != req_seen_q);

    case (state_q)
      ST_IDLE: begin
        if (req_pend) begin
          out_data_d  = bus.src_data;
          req_seen_d  = req_s_q;
          out_valid_d = 1'b1;
          state_d     = ST_VALID;
        end
      end
      ST_VALID: begin
        // A second toggle is flagged here and serviced once back in IDLE.
        if (req_pend) overrun_d = 1'b1;
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          ack_d       = ~ack_q;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    slow_ff1_d    = slow_clk;
    slow_s_d      = slow_ff1_q;
    slow_prev_d   = slow_s_q;
    rise_d        = slow_s_q & ~slow_prev_q;
    fall_d        = ~slow_s_q & slow_prev_q;
    slow_edge     = rise_q | fall_q;
    hp_inc        = (hp_cnt_q == CNT_MAX) ? CNT_MAX : hp_cnt_q + CW'(1);
    hp_cnt_d      = hp_inc;
    half_period_d = half_period_q;
    edge_seen_d   = edge_seen_q;
    hp_valid_d    = hp_valid_q;
    stall_d       = stall_q;

    if (slow_edge) begin
      half_period_d = hp_inc;
      hp_cnt_d      = '0;
      edge_seen_d   = 1'b1;
      // The first interval runs from reset, so only the second edge validates.
      if (edge_seen_q) hp_valid_d = 1'b1;
      stall_d       = 1'b0;
    end else if (hp_cnt_q == STALL_VAL) begin
      stall_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      req_ff1_q     <= 1'b0;
      req_s_q       <= 1'b0;
      req_seen_q    <= 1'b0;
      state_q       <= ST_IDLE;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      ack_q         <= 1'b0;
      overrun_q     <= 1'b0;
      slow_ff1_q    <= 1'b0;
      slow_s_q      <= 1'b0;
      slow_prev_q   <= 1'b0;
      rise_q        <= 1'b0;
      fall_q        <= 1'b0;
      hp_cnt_q      <= '0;
      half_period_q <= '0;
      edge_seen_q   <= 1'b0;
      hp_valid_q    <= 1'b0;
      stall_q       <= 1'b0;
    end else begin
      req_ff1_q     <= req_ff1_d;
      req_s_q       <= req_s_d;
      req_seen_q    <= req_seen_d;
      state_q       <= state_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      ack_q         <= ack_d;
      overrun_q     <= overrun_d;
      slow_ff1_q    <= slow_ff1_d;
      slow_s_q      <= slow_s_d;
      slow_prev_q   <= slow_prev_d;
      rise_q        <= rise_d;
      fall_q        <= fall_d;
      hp_cnt_q      <= hp_cnt_d;
      half_period_q <= half_period_d;
      edge_seen_q   <= edge_seen_d;
      hp_valid_q    <= hp_valid_d;
      stall_q       <= stall_d;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.src_ack_tgl = ack_q;
  assign overrun_err     = overrun_q;
  assign slow_rise       = rise_q;
  assign slow_fall       = fall_q;
  assign half_period     = half_period_q;
  assign hp_valid        = hp_valid_q;
  assign clk_stall       = stall_q;

endmodule

// File: tb/tb_slow_domain_rx.sv
// Directed/randomized bench for slow_domain_rx: handshake timing, backpressure, overrun,
// async reset, and a timeline model of the divided-clock monitor.
module tb_slow_domain_rx;
  localparam int DW    = 32;
  localparam int CW    = 10;
  localparam int STALL = 300;

  logic          clk_in = 1'b0;
  logic          rst_n = 1'b0;
  logic          slow_clk = 1'b0;
  logic          overrun_clr = 1'b0;
  logic          overrun_err, slow_rise, slow_fall, hp_valid, clk_stall;
  logic [CW-1:0] half_period;

  slow_domain_rx_if #(.DW(DW)) bus ();

  slow_domain_rx #(.DW(DW), .CW(CW), .STALL_LIMIT(STALL)) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .slow_clk    (slow_clk),
    .bus         (bus.slave),
    .overrun_err (overrun_err),
    .overrun_clr (overrun_clr),
    .slow_rise   (slow_rise),
    .slow_fall   (slow_fall),
    .half_period (half_period),
    .hp_valid    (hp_valid),
    .clk_stall   (clk_stall)
  );

  always #5 clk_in = ~clk_in;

  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;
  bit            exp_ack = 1'b0;
  bit            mon_chk = 1'b0;
  bit            slow_run = 1'b0;
  int            slow_half = 256;
  int            slow_cnt = 0;
  int            tog_t[$];
  bit            tog_lvl[$];
  logic [DW-1:0] word_q[$];
  logic [DW-1:0] wa, wb;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor model: strobes appear 3 ticks after slow_clk moves; each strobe is
  // absorbed one tick later, restarting the interval that half_period and stall track.
  task automatic mon_check();
    bit er;
    bit ef;
    int np;
    int sp;
    er = 1'b0;
    ef = 1'b0;
    np = 0;
    foreach (tog_t[k]) begin
      if (tog_t[k] + 3 == cyc) begin
        if (tog_lvl[k]) er = 1'b1;
        else            ef = 1'b1;
      end
      if (tog_t[k] + 4 <= cyc) np++;
    end
    chk("slow_rise", 64'(slow_rise), 64'(er));
    chk("slow_fall", 64'(slow_fall), 64'(ef));
    chk("hp_valid", 64'(hp_valid), 64'(np >= 2));
    if (np >= 1)
      chk("clk_stall", 64'(clk_stall), 64'(cyc >= tog_t[np-1] + 3 + STALL + 2));
    if (np >= 2) begin
      sp = tog_t[np-1] - tog_t[np-2];
      if (sp > 1023) sp = 1023;
      chk("half_period", 64'(half_period), 64'(sp));
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    cyc++;
    if (mon_chk) mon_check();
    if (slow_run) begin
      slow_cnt++;
      if (slow_cnt >= slow_half) begin
        slow_cnt = 0;
        slow_clk = ~slow_clk;
        tog_t.push_back(cyc);
        tog_lvl.push_back(slow_clk);
      end
    end
  endtask

  task automatic xfer(input logic [DW-1:0] d, input int hold);
    bus.src_data    = d;
    bus.src_req_tgl = ~bus.src_req_tgl;
    bus.out_ready   = (hold == 0);
    tick();
    tick();
    chk("lat_e1_valid", 64'(bus.out_valid), 64'(0));
    tick();
    chk("lat_e2_valid", 64'(bus.out_valid), 64'(1));
    chk("lat_e2_data", 64'(bus.out_data), 64'(d));
    chk("lat_e2_ack", 64'(bus.src_ack_tgl), 64'(exp_ack));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", 64'(bus.out_valid), 64'(1));
      chk("hold_data", 64'(bus.out_data), 64'(d));
      chk("hold_ack", 64'(bus.src_ack_tgl), 64'(exp_ack));
    end
    bus.out_ready = 1'b1;
    tick();
    exp_ack = ~exp_ack;
    chk("done_valid", 64'(bus.out_valid), 64'(0));
    chk("done_ack", 64'(bus.src_ack_tgl), 64'(exp_ack));
    chk("no_overrun", 64'(overrun_err), 64'(0));
    bus.out_ready = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'(0));
    chk({tag, "_data"}, 64'(bus.out_data), 64'(0));
    chk({tag, "_ack"}, 64'(bus.src_ack_tgl), 64'(0));
    chk({tag, "_overrun"}, 64'(overrun_err), 64'(0));
    chk({tag, "_rise"}, 64'(slow_rise), 64'(0));
    chk({tag, "_fall"}, 64'(slow_fall), 64'(0));
    chk({tag, "_hp"}, 64'(half_period), 64'(0));
    chk({tag, "_hpv"}, 64'(hp_valid), 64'(0));
    chk({tag, "_stall"}, 64'(clk_stall), 64'(0));
  endtask

  initial begin
    bus.src_req_tgl = 1'b0;
    bus.src_data    = '0;
    bus.out_ready   = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    xfer(32'hDEADBEEF, 0);
    xfer($urandom, 20);
    for (int i = 0; i < 6; i++) xfer($urandom, $urandom_range(0, 9));

    // Overrun: A is accepted, B toggles while A still waits for ready.
    wa = $urandom;
    wb = $urandom;
    bus.out_ready = 1'b0;
    word_q.push_back(wa);
    bus.src_data    = wa;
    bus.src_req_tgl = ~bus.src_req_tgl;
    repeat (3) tick();
    chk("ovr_a_valid", 64'(bus.out_valid), 64'(1));
    word_q.push_back(wb);
    bus.src_data    = wb;
    bus.src_req_tgl = ~bus.src_req_tgl;
    tick();
    tick();
    chk("ovr_early", 64'(overrun_err), 64'(0));
    tick();
    chk("ovr_set", 64'(overrun_err), 64'(1));
    chk("ovr_a_data", 64'(bus.out_data), 64'(word_q[0]));
    bus.out_ready = 1'b1;
    tick();
    void'(word_q.pop_front());
    exp_ack = ~exp_ack;
    chk("ovr_a_done", 64'(bus.out_valid), 64'(0));
    chk("ovr_a_ack", 64'(bus.src_ack_tgl), 64'(exp_ack));
    tick();
    chk("ovr_b_valid", 64'(bus.out_valid), 64'(1));
    chk("ovr_b_data", 64'(bus.out_data), 64'(word_q[0]));
    tick();
    void'(word_q.pop_front());
    exp_ack = ~exp_ack;
    chk("ovr_b_done", 64'(bus.out_valid), 64'(0));
    chk("ovr_b_ack", 64'(bus.src_ack_tgl), 64'(exp_ack));
    chk("ovr_sticky", 64'(overrun_err), 64'(1));
    bus.out_ready = 1'b0;
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("ovr_clr", 64'(overrun_err), 64'(0));

    // Async reset while a word is presented; the source resets its toggle too.
    bus.src_data    = $urandom;
    bus.src_req_tgl = ~bus.src_req_tgl;
    repeat (3) tick();
    chk("rst_pre_valid", 64'(bus.out_valid), 64'(1));
    #2;
    rst_n = 1'b0;
    bus.src_req_tgl = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    tick();
    tick();
    rst_n = 1'b1;
    exp_ack = 1'b0;
    tog_t.delete();
    tog_lvl.delete();
    xfer($urandom, 2);

    // Divided clock at 256 cycles per half-period.
    mon_chk   = 1'b1;
    slow_half = 256;
    slow_cnt  = 255;
    slow_run  = 1'b1;
    repeat (256 * 6) tick();
    chk("hp_256", 64'(half_period), 64'(256));
    chk("hpv_256", 64'(hp_valid), 64'(1));

    for (int i = 0; i < 4; i++) begin
      slow_half = $urandom_range(6, 180);
      repeat (slow_half * 3 + 5) tick();
    end

    // Freeze, then resume: stall rises and the long interval saturates.
    slow_run = 1'b0;
    repeat (1200) tick();
    chk("stall_set", 64'(clk_stall), 64'(1));
    slow_half = 64;
    slow_cnt  = 63;
    slow_run  = 1'b1;
    repeat (10) tick();
    chk("hp_sat", 64'(half_period), 64'(1023));
    chk("stall_clr", 64'(clk_stall), 64'(0));
    repeat (300) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/slow_domain_rx.md
# slow_domain_rx

Receive side of the slow-domain-to-clk_in link. The CPU core runs on the divided clock generated from clk_in and sends words to fast-domain peripherals over a toggle request/acknowledge handshake. This block sits in the clk_in domain and does three things: synchronizes the request, captures the word, and presents it on a valid/ready sink port. It also monitors the divided clock itself, reporting edge strobes, measured half-period and a stall flag.

## Interface
- DW, 32, data word width
- CW, 10, half-period counter width
- STALL_LIMIT, 1023, counter value that raises `clk_stall`; must be ≤ 2^CW−1

Ports:
- clk_in  in  1  fast clock; all state is on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- slow_clk  in  1  divided clock, treated as an asynchronous signal
- src_req_tgl  in  1  request toggle from the slow domain; one level change = one word
- src_data  in  DW  word from the slow domain; held stable from the toggle until the matching ack
- src_ack_tgl  out  1  ack toggle back to the slow domain
- out_valid  out  1  sink data valid
- out_data  out  DW  sink data
- out_ready  in  1  sink ready
- overrun_err  out  1  sticky: the source toggled again before being acked
- overrun_clr  in  1  synchronous clear for `overrun_err`
- slow_rise  out  1  one-cycle strobe on a synchronized rising edge of slow_clk
- slow_fall  out  1  one-cycle strobe on a synchronized falling edge of slow_clk
- half_period  out  CW  clk_in cycles between the last two slow_clk edges
- hp_valid  out  1  `half_period` holds a real measurement
- clk_stall  out  1  no slow_clk edge seen for STALL_LIMIT cycles

## Operation
**Reset.** Every output and every register resets to 0, including both 2-FF synchronizers and the internal `req_seen` bit. The source must also reset its toggle to 0.

**Request synchronization.** `src_req_tgl` passes through a 2-FF synchronizer to give `req_s`. A request is pending when `req_s != req_seen`.

**FSM.** Two states, IDLE and VALID.
- IDLE, pending request:
  - `out_data <= src_data`
  - `req_seen <= req_s`
  - `out_valid <= 1`
  - go to VALID
- VALID:
  - `out_valid` and `out_data` are held.
  - On an edge where `out_ready` = 1: `out_valid <= 0`, `src_ack_tgl <= ~src_ack_tgl`, go to IDLE.
- IDLE with no pending request: outputs hold.

**Overrun.**
- In VALID, if `req_s != req_seen`, set `overrun_err`. That second toggle is then serviced as a normal request once the FSM is back in IDLE.
- `overrun_clr` clears the flag. If a set and a clear happen on the same edge, set wins.

**Slow clock monitor.**
- slow_clk goes through its own 2-FF synchronizer plus a previous-value register.
- `slow_rise` = s & ~prev; `slow_fall` = ~s & prev. Both are registered outputs.
- Edge = `slow_rise | slow_fall`.
- `hp_cnt` (CW bits):
  - on an edge cycle: `half_period <= hp_cnt + 1` (saturating at 2^CW−1) and `hp_cnt <= 0`
  - otherwise: `hp_cnt` increments, saturating at 2^CW−1
- `hp_valid` sets on the second edge after reset and stays set. The first interval is measured from reset and is not reported as valid.
- `clk_stall` sets when `hp_cnt` = STALL_LIMIT and clears on the next edge cycle.

## Timing
- **Request latency.** Let edge E0 be the first clk_in edge that samples the new `src_req_tgl` level into FF1. Then `req_s` changes after E1, and `out_valid` = 1 after E2: 3 edges total from E0 to `out_valid` high.
- **Transfer completion.**
  - A transfer completes on the first edge with `out_valid` & `out_ready`. `out_valid` falls and `src_ack_tgl` toggles on that same edge.
  - If `out_ready` is held at 1, a back-to-back request is accepted no earlier than the edge after completion.
  - Minimum occupancy is therefore 2 clk_in cycles per word, excluding synchronizer latency.
- **Sink rules.** `out_data` is stable whenever `out_valid` = 1. `out_valid` never drops without a handshake.
- **Monitor latency.** `slow_rise`/`slow_fall` lag the slow_clk edge by 3 clk_in edges.
- **Half-period.** With the 8-bit divider, edges are 256 clk_in cycles apart, so `half_period` = 256.
- **Reset mid-transfer.** Reset mid-transfer drops `out_valid` and returns the FSM to IDLE immediately, asynchronously. The slow side must be reset at the same time.

## Test plan
- **Single word.**
  - Stimulus: reset; drive `src_data` = 0xDEADBEEF and toggle `src_req_tgl` 0→1; hold `out_ready` = 1.
  - Required: `out_valid` high 3 edges after the sampling edge with `out_data` = 0xDEADBEEF; one cycle later `out_valid` = 0 and `src_ack_tgl` = 1.
- **Backpressure.**
  - Stimulus: hold `out_ready` = 0 for 20 cycles after `out_valid` rises, then drive it to 1.
  - Required: `out_valid` and `out_data` constant for all 20 cycles; `src_ack_tgl` toggles exactly once, on the ready edge.
- **Overrun.**
  - Stimulus: toggle `src_req_tgl` twice (data A, then B) while `out_ready` = 0.
  - Required: `overrun_err` = 1; after ready, A is delivered, then B. A later `overrun_clr` pulse gives `overrun_err` = 0.
- **Divider period.**
  - Stimulus: drive slow_clk with a half-period of 256 clk_in cycles.
  - Required: alternating `slow_rise`/`slow_fall` strobes, each 1 cycle wide; `hp_valid` = 1 after the second edge; `half_period` = 256.
- **Stall.**
  - Stimulus: freeze slow_clk with STALL_LIMIT = 300.
  - Required: `clk_stall` = 1 about 300 cycles after the last edge; resuming the clock clears it on the next edge cycle; `half_period` saturates at 1023.
- **Async reset mid-VALID.**
  - Stimulus: assert `rst_n` = 0 while `out_valid` = 1.
  - Required: all outputs 0 immediately; after release, a fresh 0→1 toggle is serviced normally.
